full_st0_error_buffer: RTL and testbench

FULL_ST0_ERROR_BUFFER -- requirements
Module: full_st0_error_buffer

---
 rtl/full_st0_error_buffer_if.sv | 24 ++
 rtl/full_st0_error_buffer.sv | 55 +++++
 tb/tb_full_st0_error_buffer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/full_st0_error_buffer_if.sv
// full_st0_error_buffer_if: write strobe, readout request and tap handshake bundle
interface full_st0_error_buffer_if #(parameter int WIDTH = 32);
    logic             error_valid;
    logic [WIDTH-1:0] error_value;
    logic [1:0]       error_phase;
    logic [31:0]      error_sub_address;
    logic             rd_start;
    logic [1:0]       rd_phase;
    logic             tap_error_rdy;
    logic [WIDTH-1:0] tap_error;
    logic             tap_error_vld;
    logic             tap_error_fst;
    logic             tap_error_lst;
    logic             rd_busy;
    logic [1:0]       err_flags;
    modport master (
        output error_valid, error_value, error_phase, error_sub_address, rd_start, rd_phase, tap_error_rdy,
        input  tap_error, tap_error_vld, tap_error_fst, tap_error_lst, rd_busy, err_flags
    );
    modport slave (
        input  error_valid, error_value, error_phase, error_sub_address, rd_start, rd_phase, tap_error_rdy,
        output tap_error, tap_error_vld, tap_error_fst, tap_error_lst, rd_busy, err_flags
    );
endinterface

// File: rtl/full_st0_error_buffer.sv
// full_st0_error_buffer: phase-banked stage-0 error store with a stallable per-bank readout
module full_st0_error_buffer #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 6,
    parameter int PHASES = 4
) (
    input logic clk,
    input logic reset,
    full_st0_error_buffer_if.slave bus
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_n;
    logic [IW-1:0] rd_idx, rd_idx_n;
    logic [1:0] ph, ph_n, flags;
    logic [WIDTH-1:0] mem [PHASES][DEPTH];
    logic wr_ok, hs, last;
    assign wr_ok = bus.error_sub_address < DEPTH;
    assign hs    = state == READ && bus.tap_error_rdy;
    assign last  = rd_idx == IW'(DEPTH - 1);
    always_ff @(posedge clk)
        if (!reset && bus.error_valid && wr_ok)
            mem[bus.error_phase][bus.error_sub_address[IW-1:0]] <= bus.error_value;
    always_ff @(posedge clk)
        if (reset) begin
            state  <= IDLE;
            rd_idx <= '0;
            ph     <= '0;
            flags  <= '0;
        end else begin
            state  <= state_n;
            rd_idx <= rd_idx_n;
            ph     <= ph_n;
            flags  <= flags | {bus.rd_start && state == READ, bus.error_valid && !wr_ok};
        end
    always_comb begin
        state_n  = state;
        rd_idx_n = rd_idx;
        ph_n     = ph;
        if (state == IDLE && bus.rd_start) begin
            state_n  = READ;
            rd_idx_n = '0;
            ph_n     = bus.rd_phase;
        end else if (hs) begin
            state_n  = last ? IDLE : READ;
            rd_idx_n = last ? '0 : rd_idx + 1'b1;
        end
    end
    assign bus.rd_busy       = state == READ;
    assign bus.tap_error_vld = state == READ;
    assign bus.tap_error     = mem[ph][rd_idx];
    assign bus.tap_error_fst = state == READ && rd_idx == '0;
    assign bus.tap_error_lst = state == READ && last;
    assign bus.err_flags     = flags;
endmodule

// File: tb/tb_full_st0_error_buffer.sv
// tb_full_st0_error_buffer: directed readout scenarios checked against a bank/position model every cycle
module tb_full_st0_error_buffer;
    localparam int W = 32, D = 6, P = 4;
    logic clk = 1'b0, reset = 1'b1, go = 1'b0;
    always #5 clk = ~clk;
    full_st0_error_buffer_if #(.WIDTH(W)) bus();
    full_st0_error_buffer #(.WIDTH(W), .DEPTH(D), .PHASES(P)) dut(.clk(clk), .reset(reset), .bus(bus));
    logic [W-1:0] m [P][D];
    int pos = -1, bank = 0;
    logic [1:0] mflags = 2'b00;
    int compared = 0, mismatched = 0;
    logic [W-1:0] log_d[$];
    logic log_f[$], log_l[$];
    function automatic logic [W-1:0] fv(int p, int a);
        return p == 2 ? 32'h100 + a : 32'hA000 + p * 16 + a;
    endfunction
    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: a readout is just a bank plus a word position; -1 means no readout
    always @(posedge clk)
        if (reset) begin
            pos = -1;
            bank = 0;
            mflags = 2'b00;
        end else begin
            if (bus.error_valid) begin
                if (bus.error_sub_address < D) m[bus.error_phase][bus.error_sub_address] = bus.error_value;
                else mflags[0] = 1'b1;
            end
            if (pos >= 0) begin
                if (bus.rd_start) mflags[1] = 1'b1;
                if (bus.tap_error_rdy) pos = (pos == D - 1) ? -1 : pos + 1;
            end else if (bus.rd_start) begin
                pos = 0;
                bank = int'(bus.rd_phase);
            end
        end
    always @(negedge clk)
        if (go) begin
            chk("vld", W'(bus.tap_error_vld), W'(pos >= 0));
            chk("busy", W'(bus.rd_busy), W'(pos >= 0));
            chk("flags", W'(bus.err_flags), W'(mflags));
            if (pos >= 0) begin
                chk("data", bus.tap_error, m[bank][pos]);
                chk("fst", W'(bus.tap_error_fst), W'(pos == 0));
                chk("lst", W'(bus.tap_error_lst), W'(pos == D - 1));
            end
            if (bus.tap_error_vld) begin
                log_d.push_back(bus.tap_error);
                log_f.push_back(bus.tap_error_fst);
                log_l.push_back(bus.tap_error_lst);
            end
        end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [1:0] p, input logic [31:0] a, input logic [W-1:0] v);
        bus.error_valid = 1'b1;
        bus.error_phase = p;
        bus.error_sub_address = a;
        bus.error_value = v;
        tick();
        bus.error_valid = 1'b0;
    endtask
    task automatic start(input logic [1:0] p);
        log_d.delete();
        log_f.delete();
        log_l.delete();
        bus.rd_start = 1'b1;
        bus.rd_phase = p;
        tick();
        bus.rd_start = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 40 && bus.rd_busy; i++) tick();
        chk("idle_timeout", W'(bus.rd_busy), W'(0));
    endtask
    task automatic chk_log(string name, input logic [W-1:0] exp[$]);
        chk({name, "_len"}, W'(log_d.size()), W'(exp.size()));
        for (int i = 0; i < exp.size() && i < log_d.size(); i++) begin
            chk({name, "_d"}, log_d[i], exp[i]);
            chk({name, "_f"}, W'(log_f[i]), W'(i == 0));
            chk({name, "_l"}, W'(log_l[i]), W'(i == exp.size() - 1));
        end
    endtask
    task automatic chk_bank(string name, int p);
        logic [W-1:0] e[$];
        for (int a = 0; a < D; a++) e.push_back(fv(p, a));
        chk_log(name, e);
    endtask
    initial begin
        logic [W-1:0] e[$];
        bus.error_valid = 1'b0;
        bus.error_value = '0;
        bus.error_phase = '0;
        bus.error_sub_address = '0;
        bus.rd_start = 1'b0;
        bus.rd_phase = '0;
        bus.tap_error_rdy = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        go = 1'b1;
        #1;
        chk("reset_vld", W'(bus.tap_error_vld), W'(0));
        chk("reset_flags", W'(bus.err_flags), W'(0));
        for (int p = 0; p < P; p++)
            for (int a = 0; a < D; a++) wr(2'(p), 32'(a), fv(p, a));
        start(2);
        wait_idle();
        e = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
        chk_log("plain", e);
        start(2);
        tick();
        bus.tap_error_rdy = 1'b0;
        tick();
        tick();
        tick();
        bus.tap_error_rdy = 1'b1;
        wait_idle();
        e = '{32'h100, 32'h101, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
        chk_log("stall", e);
        wr(2'd0, 32'd6, 32'hDEAD);
        chk("oob_flag", W'(bus.err_flags), W'(2'b01));
        wr(2'd3, 32'hFFFF_FFFF, 32'hDEAD);
        for (int p = 0; p < P; p++) begin
            start(2'(p));
            wait_idle();
            chk_bank("intact", p);
        end
        start(0);
        tick();
        bus.rd_start = 1'b1;
        bus.rd_phase = 2'd3;
        tick();
        bus.rd_start = 1'b0;
        wait_idle();
        chk_bank("busy_start", 0);
        chk("busy_flag", W'(bus.err_flags), W'(2'b11));
        start(1);
        for (int i = 0; i < 5; i++) tick();
        bus.rd_start = 1'b1;
        bus.rd_phase = 2'd3;
        tick();
        bus.rd_start = 1'b0;
        chk("final_hs_start", W'(bus.rd_busy), W'(0));
        tick();
        chk("final_hs_idle", W'(bus.rd_busy), W'(0));
        start(1);
        tick();
        tick();
        tick();
        bus.tap_error_rdy = 1'b0;
        wr(2'd1, 32'd3, 32'hBEEF);
        tick();
        bus.tap_error_rdy = 1'b1;
        wait_idle();
        e = '{32'hA010, 32'hA011, 32'hA012, 32'hA013, 32'hBEEF, 32'hBEEF, 32'hA014, 32'hA015};
        chk_log("rw_collide", e);
        start(2);
        tick();
        tick();
        reset = 1'b1;
        bus.error_valid = 1'b1;
        bus.error_phase = 2'd2;
        bus.error_sub_address = 32'd0;
        bus.error_value = 32'hBAD;
        tick();
        chk("abort_vld", W'(bus.tap_error_vld), W'(0));
        chk("abort_flags", W'(bus.err_flags), W'(0));
        reset = 1'b0;
        bus.error_valid = 1'b0;
        tick();
        start(2);
        wait_idle();
        e = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
        chk_log("after_reset", e);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
